// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a synchronous FIFO and sends each word LSB-first as a
// UART-style frame (start, data, optional even parity, stop). Back-to-back
// words leave no idle gap while the FIFO still has data.
module fifo_uart_tx #(
    parameter int BITWIDTH     = 5,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                empty,
    input  logic [BITWIDTH-1:0] dIn,
    output logic                rEn,
    output logic                txd,
    output logic                busy,
    output logic                frameDone
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baudCnt_q, baudCnt_d;
    logic [BIT_W-1:0]    bitCnt_q, bitCnt_d;
    logic [BITWIDTH-1:0] shift_q, shift_d;
    logic                par_q, par_d;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;
    logic                frameDone_q, frameDone_d;
    logic                bitDone;

    // Pop request: only when data is present and the line is idle or about
    // to finish the stop bit, so the next start bit follows with no gap.
    always_comb begin
        bitDone = (baudCnt_q == BAUD_LAST);
        rEn     = !rst && !empty &&
                  ((state_q == IDLE) || ((state_q == STOP) && bitDone));
    end

    // Next-state, counters, shifter and the registered line value.
    always_comb begin
        state_d     = state_q;
        baudCnt_d   = bitDone ? '0 : baudCnt_q + 1'b1;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        frameDone_d = (state_q == STOP) && bitDone;

        if (rEn) begin
            shift_d   = dIn;
            par_d     = ^dIn;
            state_d   = START;
            baudCnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: baudCnt_d = '0;
                START: begin
                    if (bitDone) begin
                        state_d  = DATA;
                        bitCnt_d = '0;
                    end
                end
                DATA: begin
                    if (bitDone) begin
                        shift_d  = shift_q >> 1;
                        bitCnt_d = bitCnt_q + 1'b1;
                        if (bitCnt_q == BIT_LAST) begin
                            state_d  = (PARITY_EN != 0) ? PARITY : STOP;
                            bitCnt_d = '0;
                        end
                    end
                end
                PARITY: if (bitDone) state_d = STOP;
                STOP:   if (bitDone) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Line value is derived from the next state so txd is a pure flop.
        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            baudCnt_q   <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baudCnt_q   <= baudCnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign txd       = txd_q;
    assign busy      = busy_q;
    assign frameDone = frameDone_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (parity on / parity off) fed from
// queue-based FIFO models; expected line values come from a per-frame bit
// list built from the frame rules.
module tb_fifo_uart_tx;

    localparam int W   = 5;
    localparam int CPB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         emptyA, emptyB;
    logic [W-1:0] dA, dB;
    logic         rEnA, txdA, busyA, fdA;
    logic         rEnB, txdB, busyB, fdB;

    always #5 clk = ~clk;

    fifo_uart_tx #(.BITWIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dutA (
        .clk(clk), .rst(rst), .empty(emptyA), .dIn(dA),
        .rEn(rEnA), .txd(txdA), .busy(busyA), .frameDone(fdA)
    );

    fifo_uart_tx #(.BITWIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dutB (
        .clk(clk), .rst(rst), .empty(emptyB), .dIn(dB),
        .rEn(rEnB), .txd(txdB), .busy(busyB), .frameDone(fdB)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [W-1:0] fifoA[$], fifoB[$];
    bit           expA[$], lastA[$], expB[$], lastB[$];
    bit           fdPendA = 0, fdPendB = 0;
    bit           popA = 0, popB = 0;
    logic [W-1:0] w1, w2;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Bit idx of a frame: 0 start, 1..W data LSB first, then parity, then stop.
    function automatic bit exp_bit(input logic [W-1:0] w, input bit pe, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= W) return w[idx-1];
        if (pe && idx == W + 1) return ^w;
        return 1'b1;
    endfunction

    task automatic push_A(input logic [W-1:0] w);
        int len = (W + 1 + 2) * CPB;
        for (int i = 0; i < len; i++) begin
            expA.push_back(exp_bit(w, 1'b1, i / CPB));
            lastA.push_back(i == len - 1);
        end
    endtask

    task automatic push_B(input logic [W-1:0] w);
        int len = (W + 0 + 2) * CPB;
        for (int i = 0; i < len; i++) begin
            expB.push_back(exp_bit(w, 1'b0, i / CPB));
            lastB.push_back(i == len - 1);
        end
    endtask

    task automatic drive();
        emptyA = (fifoA.size() == 0);
        dA     = emptyA ? W'($urandom) : fifoA[0];
        emptyB = (fifoB.size() == 0);
        dB     = emptyB ? W'($urandom) : fifoB[0];
    endtask

    task automatic clear_models();
        expA.delete(); lastA.delete(); fdPendA = 0;
        expB.delete(); lastB.delete(); fdPendB = 0;
    endtask

    // One clock: compare at the falling edge, let the FIFO model advance
    // just after the rising edge.
    task automatic tick();
        bit eTx, eBusy, eFd, eRen, isLast;
        @(negedge clk);
        eTx = 1'b1; eBusy = 1'b0; isLast = 1'b0;
        if (expA.size() != 0) begin
            eTx = expA.pop_front(); isLast = lastA.pop_front(); eBusy = 1'b1;
        end
        eFd = fdPendA; fdPendA = isLast;
        eRen = !rst && (fifoA.size() != 0) && (expA.size() == 0);
        chk("A_txd", txdA, eTx);
        chk("A_busy", busyA, eBusy);
        chk("A_frameDone", fdA, eFd);
        chk("A_rEn", rEnA, eRen);
        chk("A_rEn_while_empty", rEnA & emptyA, 1'b0);
        popA = eRen;
        if (eRen) push_A(fifoA[0]);

        eTx = 1'b1; eBusy = 1'b0; isLast = 1'b0;
        if (expB.size() != 0) begin
            eTx = expB.pop_front(); isLast = lastB.pop_front(); eBusy = 1'b1;
        end
        eFd = fdPendB; fdPendB = isLast;
        eRen = !rst && (fifoB.size() != 0) && (expB.size() == 0);
        chk("B_txd", txdB, eTx);
        chk("B_busy", busyB, eBusy);
        chk("B_frameDone", fdB, eFd);
        chk("B_rEn", rEnB, eRen);
        chk("B_rEn_while_empty", rEnB & emptyB, 1'b0);
        popB = eRen;
        if (eRen) push_B(fifoB[0]);

        @(posedge clk);
        #1;
        if (popA) void'(fifoA.pop_front());
        if (popB) void'(fifoB.pop_front());
        drive();
    endtask

    initial begin
        emptyA = 1'b1; emptyB = 1'b1; dA = '0; dB = '0;

        // Reset held with data waiting: no pop, line idle.
        #1 rst = 1'b1;
        fifoA.push_back(5'b10110);
        drive();
        #1;
        chk("rst_txd", txdA, 1'b1);
        chk("rst_busy", busyA, 1'b0);
        chk("rst_frameDone", fdA, 1'b0);
        chk("rst_rEn", rEnA, 1'b0);
        repeat (3) tick();
        rst = 1'b0;

        // Single word 10110 with parity: pop on the first edge after release.
        repeat (40) tick();

        // Back-to-back 1F then 00 with no idle gap.
        fifoA.push_back(5'h1F);
        fifoA.push_back(5'h00);
        drive();
        repeat (75) tick();

        // Random words on both instances.
        for (int i = 0; i < 4; i++) begin
            fifoA.push_back(W'($urandom));
            fifoB.push_back(W'($urandom));
        end
        drive();
        repeat (4 * 32 + 10) tick();

        // Reset during data bit 2: line returns high at once, word dropped.
        w1 = W'($urandom);
        w2 = W'($urandom);
        fifoA.push_back(w1);
        fifoA.push_back(w2);
        drive();
        repeat (15) tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_txd", txdA, 1'b1);
        chk("midrst_busy", busyA, 1'b0);
        chk("midrst_rEn", rEnA, 1'b0);
        chk("midrst_frameDone", fdA, 1'b0);
        clear_models();
        repeat (2) tick();
        rst = 1'b0;
        repeat (40) tick();

        // Parity off: 00001 gives a 28-cycle frame.
        fifoB.push_back(5'b00001);
        drive();
        repeat (32) tick();

        // Nothing to send for 100 cycles.
        repeat (100) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
